// File: rtl/product_accumulator.sv
// Purpose: sums COUNT upstream products per batch and hands the total downstream.
// Latency: a product lands in suma/n_prod one edge after Done_Flag is sampled high.
// Backpressure: while a result awaits ack_suma, ack stays low so upstream holds its product.
module product_accumulator #(
  parameter int WIDTH     = 128,
  parameter int ACC_GUARD = 8,
  parameter int COUNT     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             producto,
  input  logic                         Done_Flag,
  output logic                         ack,
  output logic [WIDTH+ACC_GUARD-1:0]   suma,
  output logic                         valid_suma,
  input  logic                         ack_suma,
  output logic [7:0]                   n_prod,
  output logic                         overflow
);

  localparam int SW = WIDTH + ACC_GUARD;
  localparam logic [7:0] COUNT_U8 = 8'(COUNT);

  // SYNC swallows any product left pending across a reset; RELEASE waits out ack_suma.
  typedef enum logic [2:0] {
    SYNC    = 3'd0,
    IDLE    = 3'd1,
    HOLD    = 3'd2,
    PRESENT = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            ack_d;
  logic            valid_d;
  logic            ovf_d;
  logic [SW-1:0]   suma_d;
  logic [7:0]      n_prod_d;
  logic [SW:0]     sum_ext;

  // One bit wider than the accumulator so the carry-out is visible.
  assign sum_ext = {1'b0, suma} + {{(ACC_GUARD + 1){1'b0}}, producto};

  // Next-state and next-output logic; every register holds unless a state acts on it.
  always_comb begin
    state_d  = state_q;
    ack_d    = ack;
    valid_d  = valid_suma;
    ovf_d    = overflow;
    suma_d   = suma;
    n_prod_d = n_prod;
    case (state_q)
      SYNC: begin
        if (!Done_Flag) state_d = IDLE;
      end
      IDLE: begin
        if (Done_Flag) begin
          suma_d   = sum_ext[SW-1:0];
          ovf_d    = overflow | sum_ext[SW];
          n_prod_d = n_prod + 8'd1;
          ack_d    = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        // Only the falling Done_Flag ends a product, so a long pulse adds once.
        if (!Done_Flag) begin
          ack_d = 1'b0;
          if (n_prod == COUNT_U8) begin
            valid_d = 1'b1;
            state_d = PRESENT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      PRESENT: begin
        if (ack_suma) begin
          valid_d = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_suma) begin
          suma_d   = '0;
          n_prod_d = 8'd0;
          ovf_d    = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = SYNC;
      end
    endcase
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SYNC;
      ack        <= 1'b0;
      valid_suma <= 1'b0;
      overflow   <= 1'b0;
      suma       <= '0;
      n_prod     <= 8'd0;
    end else begin
      state_q    <= state_d;
      ack        <= ack_d;
      valid_suma <= valid_d;
      overflow   <= ovf_d;
      suma       <= suma_d;
      n_prod     <= n_prod_d;
    end
  end

endmodule
